cache_nway: RTL
===============

CACHE_NWAY -- requirements
Module: cache_nway

Interface
REQ-001 Parameter WAYS, default 2: associativity; SHALL be 2, 4 or 8.
REQ-002 Parameter SETS, default 64: sets per way; power of two, 2..1024.
REQ-003 Parameter WORDS, default 2: words per line; power of two, 1..8.
REQ-004 Parameter ADDR_W, default 17: word-address width.
REQ-005 Parameter DATA_W, default 32: word width.
REQ-006 Derived widths: OFF_W=log2(WORDS), IDX_W=log2(SETS), TAG_W=ADDR_W-IDX_W-OFF_W; SHALL be at least 1.
REQ-007 clk  input  1  sole clock; all state changes on its rising edge.
REQ-008 rst  input  1  synchronous, active-high reset.
REQ-009 rd_req  input  1  read request, sampled only while busy=0.
REQ-010 inv_req  input  1  invalidate request, sampled only while busy=0.
REQ-011 addr  input  ADDR_W  word address: tag=[ADDR_W-1:IDX_W+OFF_W], index=[IDX_W+OFF_W-1:OFF_W], offset=[OFF_W-1:0].
REQ-012 rd_valid  output  1  one-cycle pulse qualifying rd_data.
REQ-013 rd_data  output  DATA_W  read word.
REQ-014 busy  output  1  high whenever the FSM is not in IDLE.
REQ-015 mem_req  output  1  line-fill request to next level.
REQ-016 mem_addr  output  ADDR_W-OFF_W  line address, i.e. addr[ADDR_W-1:OFF_W].
REQ-017 mem_ready  input  1  fill data valid; ignored while mem_req=0.
REQ-018 mem_data  input  WORDS*DATA_W  fill line; word k at bits [k*DATA_W +: DATA_W].
REQ-019 hit_count, miss_count  output  16 each  read statistics counters.

Function
REQ-020 Storage per set per way: valid bit, TAG_W tag, WORDS data words, age field of log2(WAYS) bits.
REQ-021 Hit: some way has valid=1 and a matching tag; at most one way SHALL ever match.
REQ-022 FSM states: IDLE, FILL, RESP; IDLE->FILL on read miss; FILL->RESP on mem_ready; RESP->IDLE unconditionally.
REQ-023 Read hit in IDLE: the cycle after, rd_valid=1 with rd_data=the addressed word; FSM stays IDLE; hit_count increments.
REQ-024 Read miss in IDLE: the cycle after, busy=1 and mem_req=1; mem_addr and the request address are held stable until mem_ready; miss_count increments.
REQ-025 In FILL with mem_ready=1: the victim way is written (data, tag, valid=1); mem_req deasserts the next cycle.
REQ-026 In RESP: rd_valid=1 with rd_data=the offset word of the filled line; total miss latency = fill wait + 2 cycles.
REQ-027 Victim selection: the lowest-numbered invalid way; if none, the way with age=WAYS-1.
REQ-028 Age update on a read hit or fill of way w: every way in the set with age < age[w] increments, then age[w]=0; ages SHALL stay a permutation of 0..WAYS-1.
REQ-029 inv_req in IDLE with hit: valid of the matching way clears the next cycle; ages unchanged. Without hit: no effect.
REQ-030 rd_req and inv_req together: invalidation only; no rd_valid; no counter change.
REQ-031 rd_req or inv_req while busy=1: ignored; caller SHALL re-issue.
REQ-032 Counters saturate at 16'hFFFF and do not wrap.
REQ-033 rd_data holds its last value when rd_valid=0.

Reset
REQ-034 rst=1 at a clock edge: FSM->IDLE; all valid bits=0; ages of set s, way w = w; counters=0; rd_valid=0, busy=0, mem_req=0, rd_data=0.
REQ-035 Reset during FILL abandons the fill: no line is written, mem_req=0 the next cycle, and a later mem_ready is ignored.

Verification (defaults WAYS=2, SETS=64, WORDS=2)
REQ-036 Cold miss then hit:
- rd 0x00004 -> mem_req=1, mem_addr=0x00002.
- mem_ready, mem_data=0xBBBBBBBB_AAAAAAAA -> rd_valid with 0xAAAAAAAA two cycles later.
- rd 0x00005 -> rd_valid next cycle with 0xBBBBBBBB; hit_count=1, miss_count=1.
REQ-037 LRU eviction:
- Fill 0x00004, then 0x00084 (both index 2); read 0x00004 (hit).
- Fill 0x00104 -> evicts 0x00084.
- Read 0x00004 hits; read 0x00084 misses.
REQ-038 Invalidation: after filling 0x00004, inv_req 0x00004 -> the next rd 0x00004 misses; inv of an absent line changes nothing.
REQ-039 Reset mid-fill: rst during FILL, then mem_ready pulse -> no rd_valid; rd of the same address misses; counters=0.
REQ-040 Busy/collision:
- rd_req while busy=1 -> no counter change, no extra rd_valid.
- Simultaneous rd_req+inv_req on a cached line -> line invalidated, no rd_valid.
REQ-041 Saturation: force 65537 hits -> hit_count=0xFFFF.

Source files
------------

// File: rtl/cache_nway.sv
// cache_nway: N-way set-associative read cache with LRU-age replacement,
// single outstanding line fill and saturating hit/miss counters.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   rd_req, inv_req, addr read / invalidate request and word address (IDLE only)
//   rd_valid, rd_data     registered read response pulse and held word
//   busy                  high whenever the controller is not idle
//   mem_req, mem_addr     line-fill request and line address to next level
//   mem_ready, mem_data   fill handshake and full line from next level
//   hit_count, miss_count saturating read statistics
module cache_nway #(
  parameter int unsigned WAYS   = 2,
  parameter int unsigned SETS   = 64,
  parameter int unsigned WORDS  = 2,
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned DATA_W = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              rd_req,
  input  logic                              inv_req,
  input  logic [ADDR_W-1:0]                 addr,
  output logic                              rd_valid,
  output logic [DATA_W-1:0]                 rd_data,
  output logic                              busy,
  output logic                              mem_req,
  output logic [ADDR_W-$clog2(WORDS)-1:0]   mem_addr,
  input  logic                              mem_ready,
  input  logic [WORDS*DATA_W-1:0]           mem_data,
  output logic [15:0]                       hit_count,
  output logic [15:0]                       miss_count
);

  localparam int unsigned OFF_W  = $clog2(WORDS);
  localparam int unsigned IDX_W  = $clog2(SETS);
  localparam int unsigned TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int unsigned AGE_W  = $clog2(WAYS);
  localparam int unsigned WAY_W  = AGE_W;
  localparam int unsigned LINE_W = WORDS * DATA_W;
  localparam int unsigned LA_W   = ADDR_W - OFF_W;
  // Offset signal keeps at least one bit so single-word lines still elaborate.
  localparam int unsigned OFF_WS = (OFF_W > 0) ? OFF_W : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_RESP} state_t;

  state_t state_q, state_d;

  // Line storage: valid and age are reset, tag and data are not.
  logic              valid_q [SETS][WAYS];
  logic [AGE_W-1:0]  age_q   [SETS][WAYS];
  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [LINE_W-1:0] data_q  [SETS][WAYS];

  logic [ADDR_W-1:0] req_addr_q;

  logic [ADDR_W-1:0] lk_addr_c;
  logic [TAG_W-1:0]  lk_tag_c;
  logic [IDX_W-1:0]  lk_idx_c;
  logic [OFF_WS-1:0] lk_off_c;
  logic              hit_c;
  logic [WAY_W-1:0]  hit_way_c;
  logic [WAY_W-1:0]  vict_c;
  logic [WAY_W-1:0]  upd_way_c;
  logic [AGE_W-1:0]  ref_age_c;
  logic [AGE_W-1:0]  age_nxt_c [WAYS];
  logic [LINE_W-1:0] hit_line_c;
  logic [DATA_W-1:0] hit_word_c;
  logic [DATA_W-1:0] fill_word_c;
  logic              do_hit, do_miss, do_inv, do_fill;

  // While a fill is outstanding the held request address drives the lookup.
  assign lk_addr_c = (state_q == ST_IDLE) ? addr : req_addr_q;
  assign lk_tag_c  = TAG_W'(lk_addr_c >> (IDX_W + OFF_W));
  assign lk_idx_c  = IDX_W'(lk_addr_c >> OFF_W);
  assign lk_off_c  = OFF_WS'(lk_addr_c) & OFF_WS'(WORDS - 1);

  assign mem_addr  = LA_W'(req_addr_q >> OFF_W);

  // Tag compare across all ways of the addressed set.
  always_comb begin
    hit_c     = 1'b0;
    hit_way_c = '0;
    for (int w = 0; w < int'(WAYS); w++) begin
      if (valid_q[lk_idx_c][w] && (tag_q[lk_idx_c][w] == lk_tag_c)) begin
        hit_c     = 1'b1;
        hit_way_c = WAY_W'(w);
      end
    end
  end

  // Victim: lowest invalid way wins over the oldest (age WAYS-1) way.
  always_comb begin
    vict_c = '0;
    for (int w = 0; w < int'(WAYS); w++) begin
      if (age_q[lk_idx_c][w] == AGE_W'(WAYS - 1)) vict_c = WAY_W'(w);
    end
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (!valid_q[lk_idx_c][w]) vict_c = WAY_W'(w);
    end
  end

  // Word select for hit data and fill forwarding.
  assign hit_line_c = data_q[lk_idx_c][hit_way_c];

  always_comb begin
    hit_word_c  = '0;
    fill_word_c = '0;
    for (int k = 0; k < int'(WORDS); k++) begin
      if (OFF_WS'(k) == lk_off_c) begin
        hit_word_c  = hit_line_c[k*DATA_W +: DATA_W];
        fill_word_c = mem_data[k*DATA_W +: DATA_W];
      end
    end
  end

  // LRU ages: the touched way becomes 0, younger ways age by one.
  always_comb begin
    upd_way_c = do_fill ? vict_c : hit_way_c;
    ref_age_c = age_q[lk_idx_c][upd_way_c];
    for (int w = 0; w < int'(WAYS); w++) begin
      age_nxt_c[w] = age_q[lk_idx_c][w];
      if (WAY_W'(w) == upd_way_c) begin
        age_nxt_c[w] = '0;
      end else if (age_q[lk_idx_c][w] < ref_age_c) begin
        age_nxt_c[w] = age_q[lk_idx_c][w] + AGE_W'(1);
      end
    end
  end

  // Next-state and per-cycle action strobes.
  always_comb begin
    state_d = state_q;
    do_hit  = 1'b0;
    do_miss = 1'b0;
    do_inv  = 1'b0;
    do_fill = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Invalidate takes precedence over a simultaneous read.
        if (inv_req) begin
          do_inv = hit_c;
        end else if (rd_req) begin
          if (hit_c) begin
            do_hit = 1'b1;
          end else begin
            do_miss = 1'b1;
            state_d = ST_FILL;
          end
        end
      end
      ST_FILL: begin
        if (mem_ready) begin
          do_fill = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Control, response, counters, valid and age state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      busy       <= 1'b0;
      mem_req    <= 1'b0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
      hit_count  <= '0;
      miss_count <= '0;
      req_addr_q <= '0;
      for (int s = 0; s < int'(SETS); s++) begin
        for (int w = 0; w < int'(WAYS); w++) begin
          valid_q[s][w] <= 1'b0;
          age_q[s][w]   <= AGE_W'(w);
        end
      end
    end else begin
      state_q  <= state_d;
      busy     <= (state_d != ST_IDLE);
      mem_req  <= (state_d == ST_FILL);
      rd_valid <= do_hit | do_fill;
      if (do_hit)  rd_data <= hit_word_c;
      if (do_fill) rd_data <= fill_word_c;
      if (do_miss) req_addr_q <= addr;
      if (do_hit && (hit_count != 16'hFFFF))   hit_count  <= hit_count + 16'd1;
      if (do_miss && (miss_count != 16'hFFFF)) miss_count <= miss_count + 16'd1;
      if (do_fill) valid_q[lk_idx_c][vict_c]   <= 1'b1;
      if (do_inv)  valid_q[lk_idx_c][hit_way_c] <= 1'b0;
      if (do_hit || do_fill) begin
        for (int w = 0; w < int'(WAYS); w++) begin
          age_q[lk_idx_c][w] <= age_nxt_c[w];
        end
      end
    end
  end

  // Tag and data arrays; a reset in the same cycle cancels the fill write.
  always_ff @(posedge clk) begin
    if (!rst && do_fill) begin
      tag_q[lk_idx_c][vict_c]  <= lk_tag_c;
      data_q[lk_idx_c][vict_c] <= mem_data;
    end
  end

endmodule
